// File: rtl/slink_axi_tgt_pkt.sv
// AXI target side of the serial link: packs AW/W/AR into link words and
// unpacks inbound B/R words into single-entry response holding registers.
module slink_axi_tgt_pkt #(
    parameter int         AXI_ADDR_WIDTH  = 32,
    parameter int         AXI_DATA_WIDTH  = 64,
    parameter int         MAX_OUTSTANDING = 8,
    parameter logic [7:0] AW_PKT_DT       = 8'h20,
    parameter logic [7:0] W_PKT_DT        = 8'h21,
    parameter logic [7:0] B_PKT_DT        = 8'h22,
    parameter logic [7:0] AR_PKT_DT       = 8'h23,
    parameter logic [7:0] R_PKT_DT        = 8'h24,
    localparam int A  = AXI_ADDR_WIDTH,
    localparam int D  = AXI_DATA_WIDTH,
    localparam int SW = D / 8,
    localparam int OW = ((9 + D + SW) > (38 + A) ? (9 + D + SW) : (38 + A)) + 24,
    localparam int IW = D + 35
) (
    input  logic          axi_clk,
    input  logic          axi_reset,
    input  logic [7:0]    tgt_awid,
    input  logic [A-1:0]  tgt_awaddr,
    input  logic [7:0]    tgt_awlen,
    input  logic [2:0]    tgt_awsize,
    input  logic [1:0]    tgt_awburst,
    input  logic [1:0]    tgt_awlock,
    input  logic [3:0]    tgt_awcache,
    input  logic [2:0]    tgt_awprot,
    input  logic [3:0]    tgt_awqos,
    input  logic [3:0]    tgt_awregion,
    input  logic          tgt_awvalid,
    output logic          tgt_awready,
    input  logic [7:0]    tgt_wid,
    input  logic [D-1:0]  tgt_wdata,
    input  logic [SW-1:0] tgt_wstrb,
    input  logic          tgt_wlast,
    input  logic          tgt_wvalid,
    output logic          tgt_wready,
    output logic [7:0]    tgt_bid,
    output logic [1:0]    tgt_bresp,
    output logic          tgt_bvalid,
    input  logic          tgt_bready,
    input  logic [7:0]    tgt_arid,
    input  logic [A-1:0]  tgt_araddr,
    input  logic [7:0]    tgt_arlen,
    input  logic [2:0]    tgt_arsize,
    input  logic [1:0]    tgt_arburst,
    input  logic [1:0]    tgt_arlock,
    input  logic [3:0]    tgt_arcache,
    input  logic [2:0]    tgt_arprot,
    input  logic [3:0]    tgt_arqos,
    input  logic [3:0]    tgt_arregion,
    input  logic          tgt_arvalid,
    output logic          tgt_arready,
    output logic [7:0]    tgt_rid,
    output logic [D-1:0]  tgt_rdata,
    output logic [1:0]    tgt_rresp,
    output logic          tgt_rlast,
    output logic          tgt_rvalid,
    input  logic          tgt_rready,
    output logic          a2l_valid,
    input  logic          a2l_ready,
    output logic [OW-1:0] a2l_data,
    input  logic          l2a_valid,
    output logic          l2a_accept,
    input  logic [IW-1:0] l2a_data,
    output logic          err_unknown_dt
);

    localparam int CW       = 5;
    localparam int WSTRB_WC = (D <= 64) ? 1 : D / 64;

    typedef enum logic [1:0] {
        SRC_AW,
        SRC_W,
        SRC_AR
    } src_t;

    function automatic logic [OW-1:0] pack_a(
        input logic [7:0]   dt,
        input logic [7:0]   id,
        input logic [7:0]   len,
        input logic [A-1:0] addr,
        input logic [2:0]   size,
        input logic [1:0]   burst,
        input logic [1:0]   lock,
        input logic [3:0]   cache,
        input logic [2:0]   prot,
        input logic [3:0]   qos,
        input logic [3:0]   region
    );
        logic [OW-1:0] w;
        w          = '0;
        w[7:0]     = dt;
        w[23:8]    = 16'(6 + A / 8);
        w[31:24]   = id;
        w[39:32]   = len;
        w[42:40]   = size;
        w[44:43]   = burst;
        w[46:45]   = lock;
        w[50:47]   = cache;
        w[53:51]   = prot;
        w[57:54]   = qos;
        w[61:58]   = region;
        w[62 +: A] = addr;
        return w;
    endfunction

    src_t          ptr, ptr_nxt;
    logic [CW-1:0] wr_out, rd_out;
    logic [7:0]    w_credit;
    logic          aw_el, w_el, ar_el;
    logic          gnt_aw, gnt_w, gnt_ar, any_gnt, load;
    logic [OW-1:0] w_word, nxt_word;
    logic          aw_ld, wl_ld, b_hs, r_hs;
    logic [7:0]    in_dt;
    logic          is_b, is_r, b_take, r_take;
    logic          unused_ok;

    assign unused_ok = ^l2a_data[23:8];

    always_comb begin
        aw_el   = tgt_awvalid && (wr_out < CW'(MAX_OUTSTANDING));
        w_el    = tgt_wvalid && (w_credit != 8'd0);
        ar_el   = tgt_arvalid && (rd_out < CW'(MAX_OUTSTANDING));
        load    = !a2l_valid || a2l_ready;
        gnt_aw  = 1'b0;
        gnt_w   = 1'b0;
        gnt_ar  = 1'b0;
        ptr_nxt = ptr;
        case (ptr)
            SRC_AW: begin
                if (aw_el)      gnt_aw = 1'b1;
                else if (w_el)  gnt_w  = 1'b1;
                else if (ar_el) gnt_ar = 1'b1;
            end
            SRC_W: begin
                if (w_el)       gnt_w  = 1'b1;
                else if (ar_el) gnt_ar = 1'b1;
                else if (aw_el) gnt_aw = 1'b1;
            end
            default: begin
                if (ar_el)      gnt_ar = 1'b1;
                else if (aw_el) gnt_aw = 1'b1;
                else if (w_el)  gnt_w  = 1'b1;
            end
        endcase
        any_gnt = gnt_aw || gnt_w || gnt_ar;
        if (gnt_aw)      ptr_nxt = SRC_W;
        else if (gnt_w)  ptr_nxt = SRC_AR;
        else if (gnt_ar) ptr_nxt = SRC_AW;
    end

    // Ready is only ever the grant of a cycle in which the register loads.
    assign tgt_awready = axi_reset && load && gnt_aw;
    assign tgt_wready  = axi_reset && load && gnt_w;
    assign tgt_arready = axi_reset && load && gnt_ar;

    always_comb begin
        w_word                = '0;
        w_word[7:0]           = W_PKT_DT;
        w_word[23:8]          = 16'(2 + SW + WSTRB_WC);
        w_word[31:24]         = tgt_wid;
        w_word[32]            = tgt_wlast;
        w_word[33 +: SW]      = tgt_wstrb;
        w_word[33 + SW +: D]  = tgt_wdata;
        if (gnt_aw)
            nxt_word = pack_a(AW_PKT_DT, tgt_awid, tgt_awlen, tgt_awaddr,
                              tgt_awsize, tgt_awburst, tgt_awlock,
                              tgt_awcache, tgt_awprot, tgt_awqos,
                              tgt_awregion);
        else if (gnt_w)
            nxt_word = w_word;
        else
            nxt_word = pack_a(AR_PKT_DT, tgt_arid, tgt_arlen, tgt_araddr,
                              tgt_arsize, tgt_arburst, tgt_arlock,
                              tgt_arcache, tgt_arprot, tgt_arqos,
                              tgt_arregion);
    end

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            a2l_valid <= 1'b0;
            a2l_data  <= '0;
            ptr       <= SRC_AW;
        end else if (load) begin
            a2l_valid <= any_gnt;
            if (any_gnt) begin
                a2l_data <= nxt_word;
                ptr      <= ptr_nxt;
            end
        end
    end

    assign aw_ld = tgt_awready;
    assign wl_ld = tgt_wready && tgt_wlast;
    assign b_hs  = tgt_bvalid && tgt_bready;
    assign r_hs  = tgt_rvalid && tgt_rready && tgt_rlast;

    // Late or unsolicited responses must not wrap the counters below zero.
    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            wr_out   <= '0;
            rd_out   <= '0;
            w_credit <= '0;
        end else begin
            if (aw_ld && !b_hs)
                wr_out <= wr_out + CW'(1);
            else if (!aw_ld && b_hs && wr_out != '0)
                wr_out <= wr_out - CW'(1);
            if (tgt_arready && !r_hs)
                rd_out <= rd_out + CW'(1);
            else if (!tgt_arready && r_hs && rd_out != '0)
                rd_out <= rd_out - CW'(1);
            if (aw_ld && w_credit != 8'hFF)
                w_credit <= w_credit + 8'd1;
            else if (wl_ld)
                w_credit <= w_credit - 8'd1;
        end
    end

    assign in_dt  = l2a_data[7:0];
    assign is_b   = in_dt == B_PKT_DT;
    assign is_r   = in_dt == R_PKT_DT;

    always_comb begin
        l2a_accept = 1'b0;
        if (axi_reset && l2a_valid) begin
            if (is_b)      l2a_accept = !tgt_bvalid || tgt_bready;
            else if (is_r) l2a_accept = !tgt_rvalid || tgt_rready;
            else           l2a_accept = 1'b1;
        end
    end

    assign b_take = l2a_accept && is_b;
    assign r_take = l2a_accept && is_r;

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            tgt_bvalid     <= 1'b0;
            tgt_bid        <= '0;
            tgt_bresp      <= '0;
            tgt_rvalid     <= 1'b0;
            tgt_rid        <= '0;
            tgt_rresp      <= '0;
            tgt_rlast      <= 1'b0;
            tgt_rdata      <= '0;
            err_unknown_dt <= 1'b0;
        end else begin
            if (b_take) begin
                tgt_bvalid <= 1'b1;
                tgt_bid    <= l2a_data[31:24];
                tgt_bresp  <= l2a_data[33:32];
            end else if (tgt_bready) begin
                tgt_bvalid <= 1'b0;
            end
            if (r_take) begin
                tgt_rvalid <= 1'b1;
                tgt_rid    <= l2a_data[31:24];
                tgt_rresp  <= l2a_data[33:32];
                tgt_rlast  <= l2a_data[34];
                tgt_rdata  <= l2a_data[35 +: D];
            end else if (tgt_rready) begin
                tgt_rvalid <= 1'b0;
            end
            if (l2a_accept && !is_b && !is_r)
                err_unknown_dt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_slink_axi_tgt_pkt.sv
// Directed bench for slink_axi_tgt_pkt: a packet-level scoreboard checks
// every outbound word and delivered response against the field layout.
module tb_slink_axi_tgt_pkt;
    localparam int A    = 32;
    localparam int D    = 64;
    localparam int SW   = 8;
    localparam int OW   = 105;
    localparam int IW   = 99;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic [7:0]    tgt_awid, tgt_awlen, tgt_arid, tgt_arlen, tgt_wid;
    logic [A-1:0]  tgt_awaddr, tgt_araddr;
    logic [2:0]    tgt_awsize, tgt_awprot, tgt_arsize, tgt_arprot;
    logic [1:0]    tgt_awburst, tgt_awlock, tgt_arburst, tgt_arlock;
    logic [3:0]    tgt_awcache, tgt_awqos, tgt_awregion;
    logic [3:0]    tgt_arcache, tgt_arqos, tgt_arregion;
    logic          tgt_awvalid, tgt_awready, tgt_arvalid, tgt_arready;
    logic [D-1:0]  tgt_wdata, tgt_rdata;
    logic [SW-1:0] tgt_wstrb;
    logic          tgt_wlast, tgt_wvalid, tgt_wready;
    logic [7:0]    tgt_bid, tgt_rid;
    logic [1:0]    tgt_bresp, tgt_rresp;
    logic          tgt_bvalid, tgt_bready;
    logic          tgt_rlast, tgt_rvalid, tgt_rready;
    logic          a2l_valid, a2l_ready;
    logic [OW-1:0] a2l_data;
    logic          l2a_valid, l2a_accept;
    logic [IW-1:0] l2a_data;
    logic          err_unknown_dt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    slink_axi_tgt_pkt dut (
        .axi_clk(clk), .axi_reset(axi_reset),
        .tgt_awid(tgt_awid), .tgt_awaddr(tgt_awaddr), .tgt_awlen(tgt_awlen),
        .tgt_awsize(tgt_awsize), .tgt_awburst(tgt_awburst),
        .tgt_awlock(tgt_awlock), .tgt_awcache(tgt_awcache),
        .tgt_awprot(tgt_awprot), .tgt_awqos(tgt_awqos),
        .tgt_awregion(tgt_awregion), .tgt_awvalid(tgt_awvalid),
        .tgt_awready(tgt_awready),
        .tgt_wid(tgt_wid), .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb),
        .tgt_wlast(tgt_wlast), .tgt_wvalid(tgt_wvalid),
        .tgt_wready(tgt_wready),
        .tgt_bid(tgt_bid), .tgt_bresp(tgt_bresp), .tgt_bvalid(tgt_bvalid),
        .tgt_bready(tgt_bready),
        .tgt_arid(tgt_arid), .tgt_araddr(tgt_araddr), .tgt_arlen(tgt_arlen),
        .tgt_arsize(tgt_arsize), .tgt_arburst(tgt_arburst),
        .tgt_arlock(tgt_arlock), .tgt_arcache(tgt_arcache),
        .tgt_arprot(tgt_arprot), .tgt_arqos(tgt_arqos),
        .tgt_arregion(tgt_arregion), .tgt_arvalid(tgt_arvalid),
        .tgt_arready(tgt_arready),
        .tgt_rid(tgt_rid), .tgt_rdata(tgt_rdata), .tgt_rresp(tgt_rresp),
        .tgt_rlast(tgt_rlast), .tgt_rvalid(tgt_rvalid),
        .tgt_rready(tgt_rready),
        .a2l_valid(a2l_valid), .a2l_ready(a2l_ready), .a2l_data(a2l_data),
        .l2a_valid(l2a_valid), .l2a_accept(l2a_accept),
        .l2a_data(l2a_data), .err_unknown_dt(err_unknown_dt)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] m_a(
        input logic [7:0] dt, input logic [7:0] id, input logic [A-1:0] addr,
        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
        input logic [1:0] lock, input logic [3:0] cache, input logic [2:0] prot,
        input logic [3:0] qos, input logic [3:0] region);
        return OW'({addr, region, qos, prot, cache, lock, burst, size, len,
                    id, 16'(6 + A / 8), dt});
    endfunction

    function automatic logic [OW-1:0] m_w(
        input logic [7:0] id, input logic [D-1:0] data,
        input logic [SW-1:0] strb, input logic last);
        return {data, strb, last, id, 16'(2 + SW + 1), 8'h21};
    endfunction

    function automatic logic [IW-1:0] mk_b(input logic [7:0] id,
                                           input logic [1:0] resp);
        return IW'({resp, id, 16'd1, 8'h22});
    endfunction

    function automatic logic [IW-1:0] mk_r(input logic [7:0] id,
        input logic [1:0] resp, input logic last, input logic [D-1:0] data);
        return {data, last, resp, id, 16'(1 + D / 32), 8'h24};
    endfunction

    logic [OW-1:0]  exp_q[$];
    logic [9:0]     exp_b[$];
    logic [D+10:0]  exp_r[$];
    logic [7:0]     dt_log[$];
    int             model_wr, model_cr, model_rd;
    logic           prev_v, prev_r;
    logic [OW-1:0]  prev_d;

    always @(negedge clk) begin
        if (!axi_reset) begin
            exp_q.delete();
            exp_b.delete();
            exp_r.delete();
            model_wr = 0;
            model_cr = 0;
            model_rd = 0;
            prev_v = 1'b0;
            prev_r = 1'b0;
            prev_d = '0;
        end else begin
            if (prev_v && !prev_r)
                chk("a2l_hold", {a2l_valid, a2l_data}, {1'b1, prev_d});
            if (a2l_valid && a2l_ready) begin
                if (exp_q.size() == 0) chk("a2l_unexpected", 1, 0);
                else begin
                    chk("a2l_word", a2l_data, exp_q.pop_front());
                    dt_log.push_back(a2l_data[7:0]);
                end
            end
            if (tgt_awready || tgt_wready || tgt_arready)
                chk("one_ready",
                    $countones({tgt_awready, tgt_wready, tgt_arready}), 1);
            if (tgt_awready) chk("aw_limit", model_wr < MAXO, 1);
            if (tgt_wready)  chk("w_credit", model_cr > 0, 1);
            if (tgt_arready) chk("ar_limit", model_rd < MAXO, 1);
            if (tgt_awvalid && tgt_awready) begin
                exp_q.push_back(m_a(8'h20, tgt_awid, tgt_awaddr, tgt_awlen,
                    tgt_awsize, tgt_awburst, tgt_awlock, tgt_awcache,
                    tgt_awprot, tgt_awqos, tgt_awregion));
                model_wr++;
                model_cr++;
            end
            if (tgt_wvalid && tgt_wready) begin
                exp_q.push_back(m_w(tgt_wid, tgt_wdata, tgt_wstrb, tgt_wlast));
                if (tgt_wlast) model_cr--;
            end
            if (tgt_arvalid && tgt_arready) begin
                exp_q.push_back(m_a(8'h23, tgt_arid, tgt_araddr, tgt_arlen,
                    tgt_arsize, tgt_arburst, tgt_arlock, tgt_arcache,
                    tgt_arprot, tgt_arqos, tgt_arregion));
                model_rd++;
            end
            if (tgt_bvalid && tgt_bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else chk("b_resp", {tgt_bid, tgt_bresp}, exp_b.pop_front());
                if (model_wr > 0) model_wr--;
            end
            if (tgt_rvalid && tgt_rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else chk("r_beat", {tgt_rid, tgt_rresp, tgt_rlast, tgt_rdata},
                         exp_r.pop_front());
                if (tgt_rlast && model_rd > 0) model_rd--;
            end
            if (l2a_valid && l2a_accept) begin
                if (l2a_data[7:0] == 8'h22)
                    exp_b.push_back({l2a_data[31:24], l2a_data[33:32]});
                if (l2a_data[7:0] == 8'h24)
                    exp_r.push_back({l2a_data[31:24], l2a_data[33:32],
                                     l2a_data[34], l2a_data[35 +: D]});
            end
            prev_v = a2l_valid;
            prev_r = a2l_ready;
            prev_d = a2l_data;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [A-1:0] addr,
                           input logic [7:0] len);
        int t = 0;
        sync();
        tgt_awid = id; tgt_awaddr = addr; tgt_awlen = len;
        tgt_awsize = 3'd3; tgt_awburst = 2'd1; tgt_awlock = id[1:0];
        tgt_awcache = 4'h3; tgt_awprot = id[2:0]; tgt_awqos = id[3:0];
        tgt_awregion = ~id[3:0];
        tgt_awvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!tgt_awready && t < 200);
        if (!tgt_awready) chk("aw_timeout", 0, 1);
        sync();
        tgt_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [A-1:0] addr,
                           input logic [7:0] len);
        int t = 0;
        sync();
        tgt_arid = id; tgt_araddr = addr; tgt_arlen = len;
        tgt_arsize = 3'd2; tgt_arburst = 2'd2; tgt_arlock = ~id[1:0];
        tgt_arcache = 4'hA; tgt_arprot = ~id[2:0]; tgt_arqos = id[3:0];
        tgt_arregion = 4'h5;
        tgt_arvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!tgt_arready && t < 200);
        if (!tgt_arready) chk("ar_timeout", 0, 1);
        sync();
        tgt_arvalid = 1'b0;
    endtask

    task automatic wait_w();
        int t = 0;
        do begin @(negedge clk); t++; end while (!tgt_wready && t < 200);
        if (!tgt_wready) chk("w_timeout", 0, 1);
        sync();
        tgt_wvalid = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] id, input logic [D-1:0] data,
                          input logic [SW-1:0] strb, input logic last);
        sync();
        tgt_wid = id; tgt_wdata = data; tgt_wstrb = strb; tgt_wlast = last;
        tgt_wvalid = 1'b1;
        wait_w();
    endtask

    task automatic send_l2a(input logic [IW-1:0] word);
        int t = 0;
        sync();
        l2a_data = word;
        l2a_valid = 1'b1;
        do begin @(negedge clk); t++; end while (!l2a_accept && t < 200);
        if (!l2a_accept) chk("l2a_timeout", 0, 1);
        sync();
        l2a_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0)
               && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        axi_reset = 1'b0;
        {tgt_awid, tgt_awaddr, tgt_awlen, tgt_awsize, tgt_awburst} = '0;
        {tgt_awlock, tgt_awcache, tgt_awprot, tgt_awqos, tgt_awregion} = '0;
        {tgt_arid, tgt_araddr, tgt_arlen, tgt_arsize, tgt_arburst} = '0;
        {tgt_arlock, tgt_arcache, tgt_arprot, tgt_arqos, tgt_arregion} = '0;
        {tgt_wid, tgt_wdata, tgt_wstrb, tgt_wlast} = '0;
        tgt_wvalid = 1'b0;
        tgt_arvalid = 1'b0;
        tgt_bready = 1'b1;
        tgt_rready = 1'b1;
        a2l_ready = 1'b1;
        // Requests present during reset must stay unacknowledged.
        tgt_awvalid = 1'b1;
        tgt_arvalid = 1'b1;
        l2a_valid = 1'b1;
        l2a_data = IW'(8'h55);
        repeat (3) @(negedge clk);
        chk("rst_a2l_valid", a2l_valid, 0);
        chk("rst_a2l_data", a2l_data, 0);
        chk("rst_bvalid", tgt_bvalid, 0);
        chk("rst_rvalid", tgt_rvalid, 0);
        chk("rst_awready", tgt_awready, 0);
        chk("rst_wready", tgt_wready, 0);
        chk("rst_arready", tgt_arready, 0);
        chk("rst_l2a_accept", l2a_accept, 0);
        chk("rst_err", err_unknown_dt, 0);
        tgt_awvalid = 1'b0;
        tgt_arvalid = 1'b0;
        l2a_valid = 1'b0;
        sync();
        axi_reset = 1'b1;

        // Single write: AW then W word
        send_aw(8'd5, 32'h1000, 8'd0);
        @(negedge clk);
        chk("aw_dt", a2l_data[7:0], 8'h20);
        chk("aw_wc", a2l_data[23:8], 16'd10);
        chk("aw_id", a2l_data[31:24], 8'd5);
        chk("aw_addr", a2l_data[93:62], 32'h1000);
        send_w(8'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        @(negedge clk);
        chk("w_dt", a2l_data[7:0], 8'h21);
        chk("w_wc", a2l_data[23:8], 16'd11);
        chk("w_last", a2l_data[32], 1);
        chk("w_strb", a2l_data[40:33], 8'hFF);
        chk("w_data", a2l_data[104:41], 64'h0123_4567_89AB_CDEF);

        // W without a preceding AW is held back
        sync();
        tgt_wid = 8'd6; tgt_wdata = 64'hFEED_0000_0000_BEEF;
        tgt_wstrb = 8'h0F; tgt_wlast = 1'b1; tgt_wvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("w_blocked_ready", tgt_wready, 0);
            chk("w_blocked_valid", a2l_valid, 0);
        end
        dt_log.delete();
        fork
            send_aw(8'd6, 32'h2000, 8'd1);
            wait_w();
        join
        drain();
        chk("w_after_aw_n", dt_log.size(), 2);
        if (dt_log.size() == 2) begin
            chk("w_after_aw_0", dt_log[0], 8'h20);
            chk("w_after_aw_1", dt_log[1], 8'h21);
        end

        // Read outstanding limit
        dt_log.delete();
        for (int i = 0; i < MAXO; i++)
            send_ar(8'(i), 32'h3000 + 32'(i * 64), 8'd3);
        sync();
        tgt_arid = 8'd8; tgt_araddr = 32'h4000; tgt_arlen = 8'd0;
        tgt_arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ar_limit_ready", tgt_arready, 0);
        end
        send_l2a(mk_r(8'd0, 2'd1, 1'b0, 64'h1111_2222_3333_4444));
        repeat (5) begin
            @(negedge clk);
            chk("ar_nonlast_ready", tgt_arready, 0);
        end
        send_l2a(mk_r(8'd0, 2'd0, 1'b1, 64'h5555_6666_7777_8888));
        begin
            int t = 0;
            do begin @(negedge clk); t++; end while (!tgt_arready && t < 50);
            chk("ar_ninth_ready", tgt_arready, 1);
            sync();
            tgt_arvalid = 1'b0;
        end
        drain();
        chk("ar_count", dt_log.size(), 9);
        for (int i = 0; i < MAXO; i++)
            send_l2a(mk_r(8'(i + 1), 2'(i), 1'b1,
                          {32'(i), 32'hA5A5_0000 ^ 32'(i)}));
        // Unsolicited read data is still delivered
        send_l2a(mk_r(8'hEE, 2'd3, 1'b1, 64'hCAFE_F00D_0BAD_BEEF));
        drain();

        // Back-pressure with all three sources pending
        dt_log.delete();
        sync();
        a2l_ready = 1'b0;
        fork
            send_aw(8'd7, 32'h5000, 8'd0);
            send_w(8'd7, 64'h7777_0000_1234_5678, 8'hF0, 1'b1);
            send_ar(8'd9, 32'h6000, 8'd7);
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_valid", a2l_valid, 1);
                    chk("stall_dt", a2l_data[7:0], 8'h20);
                end
                sync();
                a2l_ready = 1'b1;
            end
        join
        drain();
        chk("rr_n", dt_log.size(), 3);
        if (dt_log.size() == 3) begin
            chk("rr_0", dt_log[0], 8'h20);
            chk("rr_1", dt_log[1], 8'h21);
            chk("rr_2", dt_log[2], 8'h23);
        end

        // B holding register with bready low
        sync();
        tgt_bready = 1'b0;
        send_l2a(mk_b(8'd3, 2'd2));
        @(negedge clk);
        chk("b_valid", tgt_bvalid, 1);
        chk("b_id", tgt_bid, 8'd3);
        chk("b_resp_lit", tgt_bresp, 2'd2);
        sync();
        l2a_data = mk_b(8'd4, 2'd1);
        l2a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b2_blocked", l2a_accept, 0);
            chk("b1_held", {tgt_bvalid, tgt_bid, tgt_bresp}, {1'b1, 8'd3, 2'd2});
        end
        sync();
        tgt_bready = 1'b1;
        @(negedge clk);
        chk("b2_accept", l2a_accept, 1);
        sync();
        l2a_valid = 1'b0;
        @(negedge clk);
        chk("b2_deliver", {tgt_bvalid, tgt_bid, tgt_bresp}, {1'b1, 8'd4, 2'd1});
        send_l2a(mk_b(8'd7, 2'd0));
        drain();

        // Unknown data ID
        chk("err_before", err_unknown_dt, 0);
        send_l2a(IW'({8'h12, 16'd2, 8'h55}));
        repeat (4) begin
            @(negedge clk);
            chk("err_sticky", err_unknown_dt, 1);
        end

        // Reset with a held word discards it
        sync();
        a2l_ready = 1'b0;
        send_ar(8'd10, 32'h7000, 8'd0);
        @(negedge clk);
        chk("held_before_rst", a2l_valid, 1);
        sync();
        axi_reset = 1'b0;
        @(negedge clk);
        chk("rst2_valid", a2l_valid, 0);
        chk("rst2_data", a2l_data, 0);
        chk("rst2_err", err_unknown_dt, 0);
        sync();
        axi_reset = 1'b1;
        a2l_ready = 1'b1;
        dt_log.delete();
        send_ar(8'd11, 32'h8000, 8'd2);
        drain();
        chk("post_rst_ar", dt_log.size(), 1);

        chk("end_exp_q", exp_q.size(), 0);
        chk("end_exp_b", exp_b.size(), 0);
        chk("end_exp_r", exp_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
